// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Handshake and ID/EX bus for the decode stage.
//   Fetch side   : in_valid, in_instr -> stage ; in_ready <- stage
//   Execute side : ex_ready, br_taken -> stage ; ex_* control/operand word <- stage
//   modport slave  : the decode stage itself
//   modport master : whoever drives fetch/execute (neighbouring stages or a bench)
interface decode_stage_if #(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 4
);
    logic                  in_valid;
    logic [INSTR_W-1:0]    in_instr;
    logic                  in_ready;
    logic                  ex_ready;
    logic                  br_taken;
    logic                  ex_valid;
    logic [1:0]            ex_alufunc;
    logic                  ex_branch;
    logic                  ex_flush;
    logic                  ex_regwrite;
    logic                  ex_memwrite;
    logic                  ex_memtoreg;
    logic                  ex_immediate;
    logic                  ex_forward;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [INSTR_W-1:0]    ex_imm;
    logic                  ex_illegal;

    modport slave (
        input  in_valid, in_instr, ex_ready, br_taken,
        output in_ready, ex_valid, ex_alufunc, ex_branch, ex_flush, ex_regwrite,
               ex_memwrite, ex_memtoreg, ex_immediate, ex_forward,
               ex_rd, ex_rs1, ex_rs2, ex_imm, ex_illegal
    );

    modport master (
        output in_valid, in_instr, ex_ready, br_taken,
        input  in_ready, ex_valid, ex_alufunc, ex_branch, ex_flush, ex_regwrite,
               ex_memwrite, ex_memtoreg, ex_immediate, ex_forward,
               ex_rd, ex_rs1, ex_rs2, ex_imm, ex_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
//   Instruction-decode pipeline stage: decodes the opcode into the execute
//   control word and registers it with the operand fields in ID/EX.
//   Adds load-use interlock, downstream back-pressure, a post-branch squash
//   counter and illegal-opcode flagging.
//   Ports:
//     clk   : clock, all state on rising edge
//     reset : synchronous, active-high
//     bus   : decode_stage_if.slave (fetch handshake in, ID/EX word out)
module decode_stage #(
    parameter int INSTR_W    = 16,
    parameter int OPCODE_W   = 4,
    parameter int REG_ADDR_W = 4,
    parameter int SQUASH_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);
    localparam int IMM_W = INSTR_W - OPCODE_W - REG_ADDR_W;

    typedef struct packed {
        logic [1:0] alufunc;
        logic       branch;
        logic       flush;
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       immediate;
        logic       forward;
    } ctrl_t;

    typedef enum logic {RUN, SQUASH} state_t;

    // instruction fields
    logic [OPCODE_W-1:0]   op;
    logic [REG_ADDR_W-1:0] f_rd, f_rs1, f_rs2;
    logic [INSTR_W-1:0]    f_imm;

    assign op    = bus.in_instr[INSTR_W-1 -: OPCODE_W];
    assign f_rd  = bus.in_instr[INSTR_W-OPCODE_W-1 -: REG_ADDR_W];
    assign f_rs1 = bus.in_instr[INSTR_W-OPCODE_W-REG_ADDR_W-1 -: REG_ADDR_W];
    assign f_rs2 = bus.in_instr[REG_ADDR_W-1:0];
    assign f_imm = INSTR_W'(bus.in_instr[IMM_W-1:0]);

    // opcode decode
    ctrl_t dec_ctrl;
    logic  dec_illegal;
    logic  use_rd, use_rs1, use_rs2;

    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        use_rd      = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        case (int'(op))
            0:  dec_ctrl = ctrl_t'(9'b00_0010111);                              // LDA
            1:  begin dec_ctrl = ctrl_t'(9'b00_0001010); use_rd = 1'b1; end     // STA
            2:  begin dec_ctrl = ctrl_t'(9'b00_0010001); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            3:  begin dec_ctrl = ctrl_t'(9'b01_0010001); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            4:  begin dec_ctrl = ctrl_t'(9'b10_0010001); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            5:  begin dec_ctrl = ctrl_t'(9'b11_0010001); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            6:  begin dec_ctrl = ctrl_t'(9'b00_0010011); use_rs1 = 1'b1; end
            7:  begin dec_ctrl = ctrl_t'(9'b01_0010011); use_rs1 = 1'b1; end
            8:  begin dec_ctrl = ctrl_t'(9'b10_0010011); use_rs1 = 1'b1; end
            9:  begin dec_ctrl = ctrl_t'(9'b01_1100010); use_rs1 = 1'b1; end     // BAFI
            10: begin dec_ctrl = ctrl_t'(9'b01_1100000); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            default: dec_illegal = 1'b1;
        endcase
    end

    // ID/EX register and control state
    state_t                state;
    logic [3:0]            cnt;
    logic                  r_valid;
    ctrl_t                 r_ctrl;
    logic                  r_illegal;
    logic [REG_ADDR_W-1:0] r_rd, r_rs1, r_rs2;
    logic [INSTR_W-1:0]    r_imm;

    // load-use: a load in ID/EX whose destination feeds a source of the incoming op
    logic hz;
    assign hz = r_valid & r_ctrl.memtoreg & bus.in_valid &
                ((use_rd  & (f_rd  == r_rd)) |
                 (use_rs1 & (f_rs1 == r_rd)) |
                 (use_rs2 & (f_rs2 == r_rd)));

    logic rdy;
    always_comb begin
        if (bus.br_taken || !bus.ex_ready) rdy = 1'b0;
        else if (state == SQUASH)          rdy = 1'b1;  // squashed ops are still consumed
        else                               rdy = !hz;
    end
    assign bus.in_ready = rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= '0;
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
        end else if (bus.br_taken) begin
            // wins over back-pressure: the ID/EX op is on the wrong path
            r_valid <= 1'b0;
            if (SQUASH_CYC > 0) begin
                cnt   <= 4'(SQUASH_CYC);
                state <= SQUASH;
            end else begin
                state <= RUN;
            end
        end else if (!bus.ex_ready) begin
            // hold ID/EX
        end else if (state == SQUASH) begin
            r_valid <= 1'b0;
            if (bus.in_valid) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) state <= RUN;
            end
        end else if (hz) begin
            r_valid <= 1'b0;  // bubble; fields kept, hz drops next cycle via r_valid
        end else if (bus.in_valid) begin
            r_valid   <= 1'b1;
            r_ctrl    <= dec_ctrl;
            r_illegal <= dec_illegal;
            r_rd      <= f_rd;
            r_rs1     <= f_rs1;
            r_rs2     <= f_rs2;
            r_imm     <= f_imm;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.ex_valid     = r_valid;
    assign bus.ex_alufunc   = r_ctrl.alufunc;
    assign bus.ex_branch    = r_ctrl.branch;
    assign bus.ex_flush     = r_ctrl.flush;
    assign bus.ex_regwrite  = r_ctrl.regwrite;
    assign bus.ex_memwrite  = r_ctrl.memwrite;
    assign bus.ex_memtoreg  = r_ctrl.memtoreg;
    assign bus.ex_immediate = r_ctrl.immediate;
    assign bus.ex_forward   = r_ctrl.forward;
    assign bus.ex_rd        = r_rd;
    assign bus.ex_rs1       = r_rs1;
    assign bus.ex_rs2       = r_rs2;
    assign bus.ex_imm       = r_imm;
    assign bus.ex_illegal   = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed vector table for the listed scenarios, then random traffic
//   compared cycle by cycle against a behavioural model of the stage.
module tb_decode_stage;
    localparam int SQ = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if #(.INSTR_W(16), .REG_ADDR_W(4)) bus ();

    decode_stage #(.INSTR_W(16), .OPCODE_W(4), .REG_ADDR_W(4), .SQUASH_CYC(SQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] act_ctrl();
        return {bus.ex_alufunc, bus.ex_branch, bus.ex_flush, bus.ex_regwrite,
                bus.ex_memwrite, bus.ex_memtoreg, bus.ex_immediate, bus.ex_forward};
    endfunction

    // Drive one cycle (called just after a rising edge), sample in_ready
    // before the edge and return with registered outputs settled.
    task automatic cycle(input bit r, input bit iv, input logic [15:0] ins,
                         input bit er, input bit br, output bit rdy);
        reset        = r;
        bus.in_valid = iv;
        bus.in_instr = ins;
        bus.ex_ready = er;
        bus.br_taken = br;
        #1 rdy = bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference -----------------
    logic [8:0] dtab [16];
    initial begin
        dtab = '{9'h017, 9'h00A, 9'h011, 9'h091, 9'h111, 9'h191, 9'h013, 9'h093,
                 9'h113, 9'h0E2, 9'h0E0, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    end

    // does instruction i read register a?
    function automatic bit reads(input logic [15:0] i, input logic [3:0] a);
        int o = int'(i[15:12]);
        if (o == 1) return i[11:8] == a;
        if (o == 2 || o == 3 || o == 4 || o == 5 || o == 10) return i[7:4] == a || i[3:0] == a;
        if (o >= 6 && o <= 9) return i[7:4] == a;
        return 0;
    endfunction

    bit          m_valid, m_loaded;
    logic [15:0] m_instr;
    int          m_sq;

    function automatic bit m_hz(input bit iv, input logic [15:0] ins);
        return m_valid && int'(m_instr[15:12]) == 0 && iv && reads(ins, m_instr[11:8]);
    endfunction

    // ---------------- directed vectors -----------------
    typedef struct {
        bit          r, iv, er, br;
        logic [15:0] ins;
        bit          rdy, v, ill, fld;   // fld: compare fields
        logic [8:0]  ctrl;
        logic [3:0]  rd, rs1, rs2;
        logic [15:0] imm;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit r, bit iv, logic [15:0] ins, bit er, bit br,
                                bit rdy, bit v, bit ill, bit fld, logic [8:0] ctrl,
                                logic [3:0] rd, logic [3:0] rs1, logic [3:0] rs2, logic [15:0] imm);
        vec_t t;
        t.r = r; t.iv = iv; t.ins = ins; t.er = er; t.br = br;
        t.rdy = rdy; t.v = v; t.ill = ill; t.fld = fld; t.ctrl = ctrl;
        t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
        return t;
    endfunction

    initial begin
        bit rdy;
        bit iv, er, br, r;
        logic [15:0] ins;

        // stream
        vt.push_back(mk(0,1,16'h2123,1,0, 1,1,0,1, 9'h011, 1,2,3, 16'h23));
        vt.push_back(mk(0,1,16'h6405,1,0, 1,1,0,1, 9'h013, 4,0,5, 16'h05));
        vt.push_back(mk(0,1,16'h5213,1,0, 1,1,0,1, 9'h191, 2,1,3, 16'h13));
        // load-use then independent
        vt.push_back(mk(0,1,16'h0300,1,0, 1,1,0,1, 9'h017, 3,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h2432,1,0, 0,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h2432,1,0, 1,1,0,1, 9'h011, 4,3,2, 16'h32));
        vt.push_back(mk(0,1,16'h0300,1,0, 1,1,0,1, 9'h017, 3,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h2456,1,0, 1,1,0,1, 9'h011, 4,5,6, 16'h56));
        // back-pressure holding SUB
        vt.push_back(mk(0,1,16'h3123,1,0, 1,1,0,1, 9'h091, 1,2,3, 16'h23));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(0,1,16'h2456,0,0, 0,1,0,1, 9'h091, 1,2,3, 16'h23));
        vt.push_back(mk(0,1,16'h2456,1,0, 1,1,0,1, 9'h011, 4,5,6, 16'h56));
        // branch squash with an idle gap
        vt.push_back(mk(0,1,16'h2123,1,1, 0,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h2123,1,0, 1,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,0,16'h2123,1,0, 1,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h2123,1,0, 1,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h6405,1,0, 1,1,0,1, 9'h013, 4,0,5, 16'h05));
        // illegal, BAFI
        vt.push_back(mk(0,1,16'hF000,1,0, 1,1,1,1, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h9105,1,0, 1,1,0,1, 9'h0E2, 1,0,5, 16'h05));
        // br with ex_ready low, br reload during squash, BAFR
        vt.push_back(mk(0,0,16'h0000,0,1, 0,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h2123,1,0, 1,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h2123,1,1, 0,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h2123,1,0, 1,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h2123,1,0, 1,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'hA123,1,0, 1,1,0,1, 9'h0E0, 1,2,3, 16'h23));
        // reset during squash
        vt.push_back(mk(0,0,16'h0000,1,1, 0,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(1,1,16'h2123,1,0, 1,0,0,1, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h6405,1,0, 1,1,0,1, 9'h013, 4,0,5, 16'h05));
        // reset during load-use stall
        vt.push_back(mk(0,1,16'h0300,1,0, 1,1,0,1, 9'h017, 3,0,0, 16'h00));
        vt.push_back(mk(1,1,16'h2432,1,0, 0,0,0,1, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h2432,1,0, 1,1,0,1, 9'h011, 4,3,2, 16'h32));
        // STA reads rd
        vt.push_back(mk(0,1,16'h0300,1,0, 1,1,0,1, 9'h017, 3,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h1305,1,0, 0,0,0,0, 9'h000, 0,0,0, 16'h00));
        vt.push_back(mk(0,1,16'h1305,1,0, 1,1,0,1, 9'h00A, 3,0,5, 16'h05));

        // reset
        reset = 1'b1; bus.in_valid = 1'b0; bus.in_instr = '0;
        bus.ex_ready = 1'b1; bus.br_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cycle(1, 0, 16'h0, 1, 0, rdy);
        chk("reset ex_valid", bus.ex_valid, 0);
        chk("reset ctrl", act_ctrl(), 0);
        chk("reset illegal", bus.ex_illegal, 0);
        chk("reset fields", {bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_imm}, 0);
        cycle(0, 0, 16'h0, 1, 0, rdy);
        chk("reset in_ready", rdy, 1);

        foreach (vt[i]) begin
            cycle(vt[i].r, vt[i].iv, vt[i].ins, vt[i].er, vt[i].br, rdy);
            chk($sformatf("vec%0d in_ready", i), rdy, vt[i].rdy);
            chk($sformatf("vec%0d ex_valid", i), bus.ex_valid, vt[i].v);
            if (vt[i].fld) begin
                chk($sformatf("vec%0d ctrl", i), act_ctrl(), vt[i].ctrl);
                chk($sformatf("vec%0d illegal", i), bus.ex_illegal, vt[i].ill);
                chk($sformatf("vec%0d regs", i), {bus.ex_rd, bus.ex_rs1, bus.ex_rs2},
                    {vt[i].rd, vt[i].rs1, vt[i].rs2});
                chk($sformatf("vec%0d imm", i), bus.ex_imm, vt[i].imm);
            end
        end

        // ---------------- random phase -----------------
        cycle(1, 0, 16'h0, 1, 0, rdy);
        m_valid = 0; m_loaded = 0; m_instr = '0; m_sq = 0;
        for (int n = 0; n < 3000; n++) begin
            bit exp_rdy, h;
            r   = ($urandom_range(63) == 0);
            iv  = ($urandom_range(3) != 0);
            er  = ($urandom_range(3) != 0);
            br  = ($urandom_range(15) == 0);
            ins = {4'($urandom_range(15)), 4'($urandom_range(3)),
                   4'($urandom_range(3)), 4'($urandom_range(3))};
            h = m_hz(iv, ins);
            if (br || !er)      exp_rdy = 0;
            else if (m_sq > 0)  exp_rdy = 1;
            else                exp_rdy = !h;

            cycle(r, iv, ins, er, br, rdy);

            if (r) begin
                m_valid = 0; m_loaded = 0; m_instr = '0; m_sq = 0;
            end else if (br) begin
                m_valid = 0; m_sq = SQ;
            end else if (!er) begin
            end else if (m_sq > 0) begin
                m_valid = 0;
                if (iv) m_sq = m_sq - 1;
            end else if (h) begin
                m_valid = 0;
            end else if (iv) begin
                m_valid = 1; m_loaded = 1; m_instr = ins;
            end else begin
                m_valid = 0;
            end

            if (!r) chk($sformatf("rnd%0d in_ready", n), rdy, exp_rdy);
            chk($sformatf("rnd%0d ex_valid", n), bus.ex_valid, m_valid);
            if (m_loaded) begin
                chk($sformatf("rnd%0d ctrl", n), act_ctrl(), dtab[m_instr[15:12]]);
                chk($sformatf("rnd%0d illegal", n), bus.ex_illegal, m_instr[15:12] > 4'd10);
                chk($sformatf("rnd%0d regs", n), {bus.ex_rd, bus.ex_rs1, bus.ex_rs2}, m_instr[11:0]);
                chk($sformatf("rnd%0d imm", n), bus.ex_imm, {8'h00, m_instr[7:0]});
            end else begin
                chk($sformatf("rnd%0d cleared", n),
                    {act_ctrl(), bus.ex_illegal, bus.ex_rd, bus.ex_rs1, bus.ex_rs2}, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
